// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers host bytes into an external Tx unit and
// drains them as serial frames, with an ack timeout and a flush request.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH_T = 16,
    parameter int FRAME_BITS   = 9,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                          baud_clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [7:0]                    req_data,
    input  logic                          req_par,
    output logic                          req_ready,
    input  logic                          flush,
    input  logic                          Rx_ready,
    input  logic                          PREADY_W,
    output logic                          write,
    output logic [7:0]                    data_in,
    output logic                          parity_sel,
    output logic                          start_Tx,
    output logic                          new_instruction_Tx,
    output logic [$clog2(FIFO_DEPTH_T):0] pending,
    output logic                          busy,
    output logic                          err_timeout
);
    localparam int PW = $clog2(FIFO_DEPTH_T) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [PW-1:0] DEPTH_C    = PW'(FIFO_DEPTH_T);
    localparam logic [PW-1:0] P_ONE_C    = PW'(1);
    localparam logic [PW-1:0] P_ZERO_C   = PW'(0);
    localparam logic [TW-1:0] T_ONE_C    = TW'(1);
    localparam logic [TW-1:0] T_ZERO_C   = TW'(0);
    localparam logic [TW-1:0] TMO_LAST_C = TW'(ACK_TIMEOUT - 1);
    localparam logic [BW-1:0] B_ONE_C    = BW'(1);
    localparam logic [BW-1:0] B_ZERO_C   = BW'(0);
    localparam logic [BW-1:0] BIT_LAST_C = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_ACK = 3'd2,
        ARM      = 3'd3,
        SHIFT    = 3'd4,
        GAP      = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          flush_pend_q, flush_pend_d;
    logic          err_q, err_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ready_q, write_q, start_q, newi_q, busy_q;
    logic          hs_s;

    // ready_q is only ever high in IDLE, so it doubles as the state qualifier
    assign hs_s = req_valid && ready_q;

    // Next-state, counter and datapath selection
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tmo_d     = tmo_q;
        bit_d     = bit_q;
        err_d     = err_q;
        data_d    = data_q;
        par_d     = par_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    data_d  = req_data;
                    par_d   = req_par;
                    state_d = LOAD;
                end else if ((pending_q != P_ZERO_C) &&
                             (flush_pend_q || (pending_q == DEPTH_C))) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                tmo_d   = T_ZERO_C;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack on the final allowed cycle still counts as stored
                if (PREADY_W) begin
                    pending_d = pending_q + P_ONE_C;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST_C) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + T_ONE_C;
                end
            end
            ARM: begin
                if (Rx_ready) begin
                    bit_d   = B_ZERO_C;
                    state_d = SHIFT;
                end else begin
                    state_d = ARM;
                end
            end
            SHIFT: begin
                if (bit_q == BIT_LAST_C) begin
                    pending_d = pending_q - P_ONE_C;
                    state_d   = GAP;
                end else begin
                    bit_d = bit_q + B_ONE_C;
                end
            end
            GAP: begin
                if (pending_q != P_ZERO_C) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        flush_pend_d = flush || (flush_pend_q && (pending_d != P_ZERO_C));
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pending_q    <= P_ZERO_C;
            tmo_q        <= T_ZERO_C;
            bit_q        <= B_ZERO_C;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= 8'h00;
            par_q        <= 1'b0;
            ready_q      <= 1'b1;
            write_q      <= 1'b0;
            start_q      <= 1'b0;
            newi_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            tmo_q        <= tmo_d;
            bit_q        <= bit_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
            data_q       <= data_d;
            par_q        <= par_d;
            ready_q      <= (state_d == IDLE) && (pending_d < DEPTH_C);
            write_q      <= (state_d == LOAD);
            start_q      <= (state_d == SHIFT);
            newi_q       <= (state_q == ARM) && (state_d == SHIFT);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign req_ready          = ready_q;
    assign write              = write_q;
    assign data_in            = data_q;
    assign parity_sel         = par_q;
    assign start_Tx           = start_q;
    assign new_instruction_Tx = newi_q;
    assign pending            = pending_q;
    assign busy               = busy_q;
    assign err_timeout        = err_q;

endmodule
